cbs_frame_fifo: RTL and testbench

CBS_FRAME_FIFO -- requirements
Module: cbs_frame_fifo

---
 rtl/cbs_frame_fifo_pkg.sv | 17 +
 rtl/cbs_frame_fifo_ram.sv | 28 ++
 rtl/cbs_frame_fifo.sv | 142 ++++++++++++++
 tb/tb_cbs_frame_fifo.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_frame_fifo_pkg.sv
// Shared TSN constants and helpers used by the dropper, this FIFO and the CBS shaper.
package cbs_frame_fifo_pkg;

    localparam int TSN_TDATA_WIDTH    = 8;
    localparam int TSN_FIFO_DEPTH     = 4096;
    localparam int TSN_FIFO_AF_MARGIN = 1536;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cbs_frame_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port, for block RAM inference.
// Latency: read data valid 1 cycle after rd_en_i; rd_data_o holds while rd_en_i is low.
// Backpressure: none, the caller decides when to read.
module simple_dual_port_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/cbs_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO between the frame dropper and the CBS shaper.
// Latency: first beat valid 2 cycles after its frame's tlast is written (RAM read, output register).
// Backpressure: s_axis_tready low at DEPTH stored beats; almost_full warns ALMOST_FULL_MARGIN beats early.
module cbs_frame_fifo
    import cbs_frame_fifo_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = TSN_TDATA_WIDTH,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int DEPTH              = TSN_FIFO_DEPTH,
    parameter int ALMOST_FULL_MARGIN = TSN_FIFO_AF_MARGIN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          almost_full,
    output logic [clog2(DEPTH):0]         occupancy,
    output logic [15:0]                   frame_count
);

    localparam int              AW       = clog2(DEPTH);
    localparam int              WW       = C_AXIS_TDATA_WIDTH + C_AXIS_TKEEP_WIDTH + 1;
    localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]     PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [31:0]     DEPTH_U  = 32'(DEPTH);
    localparam logic [31:0]     MARGIN_U = 32'(ALMOST_FULL_MARGIN);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cmt_ptr_q, cmt_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          ram_vld_q, ram_vld_d;
    logic          m_vld_q, m_vld_d;
    logic [WW-1:0] m_dat_q, m_dat_d;
    logic          af_q, af_d;

    logic          s_hs, m_hs, out_load, rd_en;
    logic [WW-1:0] ram_dat;
    logic [31:0]   free_w;

    // cmt_ptr marks the end of the last complete frame; nothing past it is ever read.
    assign s_axis_tready = !rst && (occ_q < DEPTH_W);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = m_vld_q && m_axis_tready;
    assign out_load      = ram_vld_q && (!m_vld_q || m_axis_tready);
    assign rd_en         = (rd_ptr_q != cmt_ptr_q) && (!ram_vld_q || out_load);
    assign free_w        = DEPTH_U - 32'(occ_q);

    simple_dual_port_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (WW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (s_hs),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (ram_dat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, s_hs};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, rd_en};
        cmt_ptr_d   = cmt_ptr_q;
        occ_d       = occ_q;
        frame_cnt_d = frame_cnt_q;
        ram_vld_d   = ram_vld_q;
        m_vld_d     = m_vld_q;
        m_dat_d     = m_dat_q;
        af_d        = free_w < MARGIN_U;

        if (s_hs && s_axis_tlast) begin
            cmt_ptr_d = wr_ptr_d;
        end

        if (s_hs && !m_hs) begin
            occ_d = occ_q + PTR_ONE;
        end else if (!s_hs && m_hs) begin
            occ_d = occ_q - PTR_ONE;
        end

        if ((s_hs && s_axis_tlast) && !(m_hs && m_dat_q[WW-1])) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (!(s_hs && s_axis_tlast) && (m_hs && m_dat_q[WW-1])) begin
            frame_cnt_d = frame_cnt_q - 16'd1;
        end

        if (rd_en) begin
            ram_vld_d = 1'b1;
        end else if (out_load) begin
            ram_vld_d = 1'b0;
        end

        if (out_load) begin
            m_vld_d = 1'b1;
            m_dat_d = ram_dat;
        end else if (m_axis_tready) begin
            m_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            occ_q       <= '0;
            frame_cnt_q <= '0;
            ram_vld_q   <= 1'b0;
            m_vld_q     <= 1'b0;
            m_dat_q     <= '0;
            af_q        <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            occ_q       <= occ_d;
            frame_cnt_q <= frame_cnt_d;
            ram_vld_q   <= ram_vld_d;
            m_vld_q     <= m_vld_d;
            m_dat_q     <= m_dat_d;
            af_q        <= af_d;
        end
    end

    assign m_axis_tvalid = m_vld_q;
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_dat_q;
    assign almost_full   = af_q;
    assign occupancy     = occ_q;
    assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_cbs_frame_fifo.sv
// Bench for cbs_frame_fifo: randomized frames against a queue-based model of stored beats.
module tb_cbs_frame_fifo;

    localparam int DEPTH  = 4096;
    localparam int MARGIN = 1536;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic [0:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  m_axis_tdata;
    logic [0:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        almost_full;
    logic [12:0] occupancy;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    cbs_frame_fifo #(
        .C_AXIS_TDATA_WIDTH (8),
        .C_AXIS_TKEEP_WIDTH (1),
        .DEPTH              (DEPTH),
        .ALMOST_FULL_MARGIN (MARGIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .almost_full   (almost_full),
        .occupancy     (occupancy),
        .frame_count   (frame_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  mq[$];          // beats accepted and not yet delivered: {tlast, tkeep, tdata}
    int          fc_model = 0;   // complete frames in mq
    bit          af_exp = 1'b0;
    bit          s_hs, m_hs;
    logic [9:0]  got, exp;

    function automatic logic [9:0] mk(input bit last);
        return {last, 1'($urandom), 8'($urandom)};
    endfunction

    // Called at a negedge: applies inputs, works out which handshakes the next edge takes, updates the model.
    task automatic drive(input bit sv, input logic [9:0] b, input bit mr);
        s_axis_tvalid = sv;
        {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = b;
        m_axis_tready = mr;
        #1;
        s_hs   = sv && s_axis_tready;
        m_hs   = m_axis_tvalid && mr;
        got    = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        exp    = 'x;
        af_exp = (DEPTH - mq.size()) < MARGIN;
        if (m_hs && mq.size() > 0) begin
            exp = mq.pop_front();
            if (exp[9]) fc_model--;
        end
        if (s_hs) begin
            mq.push_back(b);
            if (b[9]) fc_model++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", s_axis_tready); end
        n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL rst_occ: got %0d expected 0", occupancy); end
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL rst_fc: got %0d expected 0", frame_count); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b expected 0", m_axis_tvalid); end
        n_vec++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast: got %b expected 0", m_axis_tlast); end
        n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af: got %b expected 0", almost_full); end
        rst = 1'b0;
        mq.delete(); fc_model = 0; af_exp = 1'b0;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL post_rst_tready: got %b expected 1", s_axis_tready); end
    endtask

    task automatic test_single_frame();
        logic [9:0] data[64];
        int in_i = 0, out_i = 0, cyc = 0, t_last = -1, t_vld = -1;
        bit saw1 = 1'b0;
        for (int i = 0; i < 64; i++) data[i] = mk(i == 63);
        while (out_i < 64 && cyc < 400) begin
            @(negedge clk);
            n_vec++; if (occupancy !== 13'(mq.size())) begin n_err++; $display("FAIL single_occ: got %0d expected %0d", occupancy, mq.size()); end
            n_vec++; if (frame_count !== 16'(fc_model)) begin n_err++; $display("FAIL single_fc: got %0d expected %0d", frame_count, fc_model); end
            if (frame_count == 16'd1) saw1 = 1'b1;
            if (m_axis_tvalid && t_vld < 0) t_vld = cyc;
            drive(in_i < 64, data[in_i % 64], 1'b1);
            if (s_hs) begin
                if (in_i == 63) t_last = cyc;
                in_i++;
            end
            if (m_hs) begin
                n_vec++; if (got !== data[out_i]) begin n_err++; $display("FAIL single_data[%0d]: got %h expected %h", out_i, got, data[out_i]); end
                out_i++;
            end
            cyc++;
        end
        n_vec++; if (out_i != 64) begin n_err++; $display("FAIL single_beats: got %0d expected 64", out_i); end
        // tvalid registers on the second edge after the tlast edge, i.e. the third negedge after driving tlast.
        n_vec++; if (t_vld - t_last != 3) begin n_err++; $display("FAIL single_latency: got %0d expected 3", t_vld - t_last); end
        n_vec++; if (!saw1) begin n_err++; $display("FAIL single_fc_one: got 0 expected 1"); end
        @(negedge clk);
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL single_fc_end: got %0d expected 0", frame_count); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL single_tvalid_end: got %b expected 0", m_axis_tvalid); end
    endtask

    task automatic test_partial();
        test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, mk(1'b0), 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL partial_tvalid: got %b expected 0", m_axis_tvalid); end
            drive(1'b0, 10'd0, 1'b1);
        end
        n_vec++; if (occupancy !== 13'd10) begin n_err++; $display("FAIL partial_occ: got %0d expected 10", occupancy); end
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL partial_fc: got %0d expected 0", frame_count); end
    endtask

    task automatic test_almost_full();
        int prev_occ = 0;
        bit rose = 1'b0;
        test_reset();
        for (int i = 0; i < 4100; i++) begin
            @(negedge clk);
            n_vec++; if (almost_full !== af_exp) begin n_err++; $display("FAIL af_level: got %b expected %b at occ %0d", almost_full, af_exp, occupancy); end
            n_vec++; if (s_axis_tready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL af_tready: got %b at occ %0d", s_axis_tready, occupancy); end
            n_vec++; if (occupancy !== 13'(mq.size())) begin n_err++; $display("FAIL af_occ: got %0d expected %0d", occupancy, mq.size()); end
            if (almost_full && !rose) begin
                rose = 1'b1;
                n_vec++; if (prev_occ != 2561) begin n_err++; $display("FAIL af_rise: got occ %0d before rise expected 2561", prev_occ); end
            end
            prev_occ = occupancy;
            drive(1'b1, mk(1'b0), 1'b0);
        end
        n_vec++; if (!rose) begin n_err++; $display("FAIL af_never_rose: got 0 expected 1"); end
        n_vec++; if (occupancy !== 13'd4096) begin n_err++; $display("FAIL af_full_occ: got %0d expected 4096", occupancy); end
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL af_full_tready: got %b expected 0", s_axis_tready); end
    endtask

    task automatic test_simultaneous();
        int coincide = 0, pre_occ = -1, pre_fc = 0, guard = 0;
        logic [9:0] b;
        test_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(1'b1, mk(i % 3 == 2), 1'b0);
        end
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 10'd0, 1'b0);
        end
        // Nine stored beats with both sides streaming keeps input and output tlasts in phase.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pre_occ >= 0) begin
                n_vec++; if (occupancy !== 13'(pre_occ)) begin n_err++; $display("FAIL simul_occ: got %0d expected %0d", occupancy, pre_occ); end
                n_vec++; if (frame_count !== 16'(pre_fc)) begin n_err++; $display("FAIL simul_fc: got %0d expected %0d", frame_count, pre_fc); end
            end
            n_vec++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL b2b_bubble: got %b expected 1", m_axis_tvalid); end
            pre_occ = occupancy; pre_fc = frame_count;
            b = mk(i % 3 == 2);
            drive(1'b1, b, 1'b1);
            if (m_hs) begin
                n_vec++; if (got !== exp) begin n_err++; $display("FAIL simul_data: got %h expected %h", got, exp); end
            end
            if (s_hs && b[9] && m_hs && got[9]) coincide++;
            else pre_occ = -1;
        end
        n_vec++; if (coincide == 0) begin n_err++; $display("FAIL simul_events: got 0 expected >0"); end
        while (mq.size() > 0 && guard < 200) begin
            @(negedge clk);
            drive(1'b0, 10'd0, 1'b1);
            if (m_hs) begin
                n_vec++; if (got !== exp) begin n_err++; $display("FAIL simul_drain: got %h expected %h", got, exp); end
            end
            guard++;
        end
        @(negedge clk);
        n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL simul_empty_occ: got %0d expected 0", occupancy); end
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL simul_empty_fc: got %0d expected 0", frame_count); end
    endtask

    task automatic test_stream(input int nframes, input int minlen, input int maxlen,
                               input int vld_pct, input int rdy_pct);
        int fi = 0, bi = 0, cyc = 0, flen;
        bit sv, mr, stall = 1'b0;
        logic [9:0] held = '0;
        flen = $urandom_range(maxlen, minlen);
        while ((fi < nframes || mq.size() > 0) && cyc < 70000) begin
            @(negedge clk);
            n_vec++; if (occupancy !== 13'(mq.size())) begin n_err++; $display("FAIL stream_occ: got %0d expected %0d", occupancy, mq.size()); end
            n_vec++; if (frame_count !== 16'(fc_model)) begin n_err++; $display("FAIL stream_fc: got %0d expected %0d", frame_count, fc_model); end
            n_vec++; if (almost_full !== af_exp) begin n_err++; $display("FAIL stream_af: got %b expected %b", almost_full, af_exp); end
            if (stall) begin
                n_vec++; if (m_axis_tvalid !== 1'b1 || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== held) begin
                    n_err++; $display("FAIL stream_hold: got v=%b %h expected v=1 %h", m_axis_tvalid, {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, held);
                end
            end
            if (m_axis_tvalid) begin
                n_vec++; if (fc_model < 1) begin n_err++; $display("FAIL stream_store_fwd: got tvalid 1 with %0d complete frames, expected >0", fc_model); end
            end
            sv = (fi < nframes) && ($urandom_range(99, 0) < vld_pct);
            mr = $urandom_range(99, 0) < rdy_pct;
            drive(sv, mk(bi == flen - 1), mr);
            if (s_hs) begin
                bi++;
                if (bi == flen) begin
                    bi = 0; fi++;
                    flen = $urandom_range(maxlen, minlen);
                end
            end
            if (m_hs) begin
                n_vec++; if (got !== exp) begin n_err++; $display("FAIL stream_data: got %h expected %h", got, exp); end
            end
            stall = m_axis_tvalid && !mr;
            held  = got;
            cyc++;
        end
        n_vec++; if (cyc >= 70000) begin n_err++; $display("FAIL stream_timeout: got %0d frames sent, %0d beats pending, expected all delivered", fi, mq.size()); end
        @(negedge clk);
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        n_vec++; if (occupancy !== 13'd0) begin n_err++; $display("FAIL stream_end_occ: got %0d expected 0", occupancy); end
        n_vec++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL stream_end_fc: got %0d expected 0", frame_count); end
    endtask

    task automatic test_reset_mid_frame();
        test_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(1'b1, mk(i % 5 == 4), 1'b0);
        end
        @(negedge clk);
        n_vec++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL midrst_fc_before: got %0d expected 3", frame_count); end
        n_vec++; if (occupancy !== 13'd17) begin n_err++; $display("FAIL midrst_occ_before: got %0d expected 17", occupancy); end
        test_reset();
        test_stream(1, 60, 60, 100, 100);
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_frame();
        test_partial();
        test_almost_full();
        test_simultaneous();
        test_reset_mid_frame();
        test_reset();
        test_stream(1000, 1, 32, 75, 75);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
